stp_rx_controller: RTL

//  Receive-side sequencer for the LSB-first serial-to-parallel shift register (stp_sr_*).

---
 rtl/stp_rx_pkg.sv | 10 +
 rtl/stp_rx_timer.sv | 27 ++
 rtl/stp_rx_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stp_rx_pkg.sv
// Shared types and default sizing for the serial receive sequencer.
`timescale 1ns/1ps
package stp_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} rx_state_t;

  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10;

endpackage

// File: rtl/stp_rx_timer.sv
// Rollover counter with clear; rollover_flag marks the terminal count value.
`timescale 1ns/1ps
module stp_rx_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count,
  output logic         rollover_flag
);

  assign rollover_flag = (count == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= rollover_flag ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/stp_rx_controller.sv
// Receive sequencer: start detect, mid-bit sampling, SR shift strobes, stop check,
// buffer load and sticky ready/error flags. All outputs are registered.
`timescale 1ns/1ps
module stp_rx_controller
  import stp_rx_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic busy
);

  localparam int TW   = $clog2(CLKS_PER_BIT + 1);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  rx_state_t     state, next_state;
  logic          line_prev;
  logic          start_edge;
  logic          sample_p;
  logic          tick;
  logic          timer_clear, timer_en;
  logic [TW-1:0] bit_time;
  logic          bit_tc;
  logic [BW-1:0] bit_cnt;
  logic          bit_full;
  logic          shift_enable_d, load_buffer_d, data_ready_d;
  logic          framing_error_d, overrun_error_d, busy_d;

  assign start_edge = (state == IDLE) && line_prev && !serial_in;

  // tick fires one cycle before each sample point so the registered strobes land on it.
  // The START half-bit is taken from the raw count; clearing there phases the bit timer.
  always_comb begin
    tick = 1'b0;
    if (state == START)
      tick = !sample_p && (bit_time == TW'(HALF - 2));
    else if ((state == DATA) || (state == STOP))
      tick = bit_tc;
  end

  assign timer_en    = (state == START) || (state == DATA) || (state == STOP);
  assign timer_clear = !timer_en || ((state == START) && tick);

  stp_rx_timer #(.W(TW)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (timer_clear),
    .count_enable (timer_en),
    .rollover_val (TW'(CLKS_PER_BIT - 1)),
    .count        (bit_time),
    .rollover_flag(bit_tc)
  );

  // Terminal count at DATA_BITS gates further counting, so the bit count saturates.
  stp_rx_timer #(.W(BW)) u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (start_edge),
    .count_enable (shift_enable && !bit_full),
    .rollover_val (BW'(DATA_BITS)),
    .count        (bit_cnt),
    .rollover_flag(bit_full)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      line_prev <= 1'b1;
      sample_p  <= 1'b0;
    end else begin
      state     <= next_state;
      line_prev <= serial_in;
      sample_p  <= tick;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_edge) next_state = START;
      START:   if (sample_p) next_state = serial_in ? IDLE : DATA;
      DATA:    if (shift_enable && (bit_cnt == BW'(DATA_BITS - 1))) next_state = STOP;
      STOP:    if (sample_p) next_state = serial_in ? LOAD : IDLE;
      LOAD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    shift_enable_d  = (state == DATA) && tick;
    load_buffer_d   = (state == STOP) && sample_p && serial_in;
    busy_d          = (next_state != IDLE);
    framing_error_d = framing_error;
    if (start_edge)
      framing_error_d = 1'b0;
    else if ((state == STOP) && sample_p && !serial_in)
      framing_error_d = 1'b1;
    data_ready_d = data_ready;
    if (state == LOAD)
      data_ready_d = 1'b1;
    else if (data_read)
      data_ready_d = 1'b0;
    overrun_error_d = overrun_error;
    if (data_read)
      overrun_error_d = 1'b0;
    else if ((state == LOAD) && data_ready)
      overrun_error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_enable  <= 1'b0;
      load_buffer   <= 1'b0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      shift_enable  <= shift_enable_d;
      load_buffer   <= load_buffer_d;
      data_ready    <= data_ready_d;
      framing_error <= framing_error_d;
      overrun_error <= overrun_error_d;
      busy          <= busy_d;
    end
  end

endmodule
